// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter steering one of four requesters onto a shared register's d input.
// Optional locked bursts are enabled with `define ARB_LOCK_EN.
module reg_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] wdata_i,
`ifdef ARB_LOCK_EN
  input  logic [3:0]         lock_i,
`endif
  input  logic [WIDTH-1:0]   ff_q_i,
  output logic [WIDTH-1:0]   ff_d_o,
  output logic [3:0]         ack_o,
  output logic [1:0]         owner_o,
  output logic               busy_o
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be in 1..15");
  end

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] win;
`ifdef ARB_LOCK_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    win = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req_i[idx]) win = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_o   = '0;
    ff_d_o  = ff_q_i;
`ifdef ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = win;
          state_d = S_WRITE;
`ifdef ARB_LOCK_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WRITE: begin
        if (req_i[owner_q]) begin
          ff_d_o         = wdata_i[owner_q*WIDTH +: WIDTH];
          ack_o[owner_q] = 1'b1;
        end
`ifdef ARB_LOCK_EN
        if (req_i[owner_q] && lock_i[owner_q] && ((cnt_q + 4'd1) < 4'(MAX_BURST))) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          ptr_d   = owner_q + 2'd1;
        end
`else
        state_d = S_IDLE;
        ptr_d   = owner_q + 2'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // The register resets in this same cycle, so nothing may be acknowledged.
    if (rst_i) begin
      ack_o  = '0;
      ff_d_o = ff_q_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q == S_WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the shared register.
module tb_reg_write_arbiter;
  localparam int WIDTH = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [3:0]         req_i;
  logic [4*WIDTH-1:0] wdata_i;
  logic [3:0]         lock_i;
  logic [WIDTH-1:0]   ff_q_i;
  logic [WIDTH-1:0]   ff_d_o;
  logic [3:0]         ack_o;
  logic [1:0]         owner_o;
  logic               busy_o;

  int total = 0;
  int bad   = 0;

  reg_write_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .wdata_i (wdata_i),
`ifdef ARB_LOCK_EN
    .lock_i  (lock_i),
`endif
    .ff_q_i  (ff_q_i),
    .ff_d_o  (ff_d_o),
    .ack_o   (ack_o),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q_i <= '0;
    else       ff_q_i <= ff_d_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b1;
    req_i   = 4'hF;
    lock_i  = 4'h0;
    wdata_i = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held two cycles with all requests raised
    next_cycle();
    chk("rst_ack", 32'(ack_o), 32'h0);
    next_cycle();
    chk("rst_ack2", 32'(ack_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_ffq", 32'(ff_q_i), 32'h0);

    // Single request from requester 1
    rst_i   = 1'b0;
    req_i   = 4'b0010;
    wdata_i = {8'h44, 8'h33, 8'hA5, 8'h11};
    #1;
    chk("single_c0_ack", 32'(ack_o), 32'h0);
    chk("single_c0_ffd", 32'(ff_d_o), 32'h0);
    next_cycle();
    chk("single_c1_ack", 32'(ack_o), 32'b0010);
    chk("single_c1_owner", 32'(owner_o), 32'h1);
    chk("single_c1_busy", 32'(busy_o), 32'h1);
    chk("single_c1_ffd", 32'(ff_d_o), 32'hA5);
    next_cycle();
    req_i = 4'b0000;
    #1;
    chk("single_c2_ack", 32'(ack_o), 32'h0);
    chk("single_c2_ffq", 32'(ff_q_i), 32'hA5);
    chk("single_c2_busy", 32'(busy_o), 32'h0);

    // Pointer back to 0, then all four at once
    rst_i = 1'b1;
    next_cycle();
    rst_i   = 1'b0;
    req_i   = 4'hF;
    wdata_i = {8'h44, 8'h33, 8'h22, 8'h11};
    next_cycle();
    chk("all_c1_ack", 32'(ack_o), 32'b0001);
    chk("all_c1_owner", 32'(owner_o), 32'h0);
    next_cycle();
    req_i = 4'b1110;
    #1;
    chk("all_c2_ack", 32'(ack_o), 32'h0);
    chk("all_c2_ffq", 32'(ff_q_i), 32'h11);
    next_cycle();
    chk("all_c3_ack", 32'(ack_o), 32'b0010);
    chk("all_c3_owner", 32'(owner_o), 32'h1);
    next_cycle();
    req_i = 4'b1100;
    #1;
    chk("all_c4_ffq", 32'(ff_q_i), 32'h22);
    next_cycle();
    chk("all_c5_ack", 32'(ack_o), 32'b0100);
    next_cycle();
    req_i = 4'b1000;
    #1;
    chk("all_c6_ffq", 32'(ff_q_i), 32'h33);
    next_cycle();
    chk("all_c7_ack", 32'(ack_o), 32'b1000);
    chk("all_c7_owner", 32'(owner_o), 32'h3);
    next_cycle();
    req_i = 4'b0000;
    #1;
    chk("all_c8_ffq", 32'(ff_q_i), 32'h44);

    // Wrap after grant to 3: 0 beats 2
    req_i = 4'b0101;
    next_cycle();
    chk("wrap3_first", 32'(ack_o), 32'b0001);
    next_cycle();
    req_i = 4'b0100;
    #1;
    chk("wrap3_idle_ack", 32'(ack_o), 32'h0);
    next_cycle();
    chk("wrap3_second", 32'(ack_o), 32'b0100);
    next_cycle();
    req_i = 4'b0010;
    next_cycle();
    chk("wrap1_grant1", 32'(ack_o), 32'b0010);
    next_cycle();
    req_i = 4'b0101;
    next_cycle();
    chk("wrap1_first", 32'(ack_o), 32'b0100);
    chk("wrap1_first_owner", 32'(owner_o), 32'h2);
    next_cycle();
    req_i = 4'b0001;
    next_cycle();
    chk("wrap1_second", 32'(ack_o), 32'b0001);
    next_cycle();
    req_i = 4'b0000;
    #1;
    chk("wrap_ffq", 32'(ff_q_i), 32'h11);

    // Requester 2 withdraws in its WRITE cycle
    req_i   = 4'b0100;
    wdata_i = {8'h44, 8'h99, 8'h22, 8'h11};
    next_cycle();
    req_i = 4'b0000;
    #1;
    chk("wd_ack", 32'(ack_o), 32'h0);
    chk("wd_busy", 32'(busy_o), 32'h1);
    chk("wd_ffd", 32'(ff_d_o), 32'h11);
    next_cycle();
    chk("wd_idle_busy", 32'(busy_o), 32'h0);
    chk("wd_ffq", 32'(ff_q_i), 32'h11);

    // Reset arriving during a WRITE cycle
    req_i   = 4'b1000;
    wdata_i = {8'h77, 8'h99, 8'h22, 8'h11};
    next_cycle();
    rst_i = 1'b1;
    #1;
    chk("rstw_ack", 32'(ack_o), 32'h0);
    next_cycle();
    rst_i = 1'b0;
    req_i = 4'b1100;
    #1;
    chk("rstw_ffq", 32'(ff_q_i), 32'h0);
    chk("rstw_busy", 32'(busy_o), 32'h0);
    chk("rstw_owner", 32'(owner_o), 32'h0);
    next_cycle();
    chk("rstw_ptr0_ack", 32'(ack_o), 32'b0100);
    chk("rstw_ptr0_owner", 32'(owner_o), 32'h2);
    next_cycle();
    req_i = 4'b0000;
    #1;
    chk("rstw_ffq2", 32'(ff_q_i), 32'h99);

`ifdef ARB_LOCK_EN
    // Locked burst of four, requester 0 pending behind it
    req_i = 4'b0010;
    next_cycle();
    next_cycle();
    req_i  = 4'b0101;
    lock_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk("lock_burst_ack", 32'(ack_o), 32'b0100);
      chk("lock_burst_busy", 32'(busy_o), 32'h1);
    end
    next_cycle();
    chk("lock_end_ack", 32'(ack_o), 32'h0);
    chk("lock_end_busy", 32'(busy_o), 32'h0);
    next_cycle();
    chk("lock_next_ack", 32'(ack_o), 32'b0001);
    next_cycle();
    req_i  = 4'b0000;
    lock_i = 4'b0000;
    #1;
    chk("lock_ffq", 32'(ff_q_i), 32'h11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
